// File: rtl/karatsuba_combine_seq_pkg.sv
// Shared constants, state encoding and per-op subtract table for the
// Karatsuba final-combine stage.
package karatsuba_combine_seq_pkg;

  localparam int W     = 32;
  localparam int W2    = 2 * W;
  localparam int WH    = W / 2;
  localparam int N_OPS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD_LO = 2'd1,
    ADD_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD_Z1 = 2'd0;
  localparam op_t OP_SUB_Z0 = 2'd1;
  localparam op_t OP_SUB_Z2 = 2'd2;
  localparam op_t LAST_OP   = op_t'(N_OPS - 1);

  // Subtract ops add the one's complement and inject the +1 as low-word carry-in.
  localparam logic [3:0] SUB_TABLE = 4'b0110;

  function automatic logic isSubtract(input op_t op);
    return SUB_TABLE[op];
  endfunction

  function automatic op_t nextOp(input op_t op);
    return {op[1] ^ op[0], ~op[0]};
  endfunction

endpackage

// File: rtl/karatsuba_combine_seq_if.sv
// Handshake and data bundle between the partial-product stage, the combine
// stage and its consumer.
interface karatsuba_combine_seq_if;
  import karatsuba_combine_seq_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  z0;
  logic [W+1:0]  z1;
  logic [W-1:0]  z2;
  logic          out_valid;
  logic          out_ready;
  logic [W2-1:0] product;
  logic          busy;

  modport master (
    output in_valid, z0, z1, z2, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, z0, z1, z2, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/karatsuba_combine_seq_lf32.sv
// 32-bit Ladner-Fischer parallel-prefix adder with carry-in and carry-out.
module LadnerFischer32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [31:0] w_p;
  logic [31:0] w_g;
  logic [31:0] w_pp;

  // Each level only modifies bits whose span index has bit k set; the source
  // bit j always has bit k clear, so the in-place update is order-safe.
  always_comb begin
    w_p  = i_a ^ i_b;
    w_g  = i_a & i_b;
    w_g[0] = w_g[0] | (w_p[0] & i_cin);
    w_pp = w_p;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 32; i++) begin
        if (((i >> k) & 1) != 0) begin
          w_g[i]  = w_g[i] | (w_pp[i] & w_g[((i >> k) << k) - 1]);
          w_pp[i] = w_pp[i] & w_pp[((i >> k) << k) - 1];
        end
      end
    end
  end

  assign o_sum  = w_p ^ {w_g[30:0], i_cin};
  assign o_cout = w_g[31];

endmodule

// File: rtl/karatsuba_combine_seq.sv
// Sequential Karatsuba combine: P = z2<<32 + (z1 - z0 - z2)<<16 + z0, built from
// six passes through one shared 32-bit adder.
module karatsuba_combine_seq
  import karatsuba_combine_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  karatsuba_combine_seq_if.slave    bus
);

  state_t        r_state;
  state_t        w_nextState;
  op_t           r_op;
  logic [W2-1:0] r_acc;
  logic [W2-1:0] r_product;
  logic [W-1:0]  r_z0;
  logic [W+1:0]  r_z1;
  logic [W-1:0]  r_z2;
  logic          r_carry;

  logic          w_accept;
  logic          w_isLo;
  logic [W2-1:0] w_opnd;
  logic [W-1:0]  w_addA;
  logic [W-1:0]  w_addB;
  logic          w_addCin;
  logic [W-1:0]  w_sum;
  logic          w_cout;

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_isLo   = (r_state == ADD_LO);

  always_comb begin
    w_opnd = '0;
    case (r_op)
      OP_ADD_Z1: w_opnd =  {{(W2 - W - 2 - WH){1'b0}}, r_z1, {WH{1'b0}}};
      OP_SUB_Z0: w_opnd = ~{{(W2 - W - WH){1'b0}}, r_z0, {WH{1'b0}}};
      default:   w_opnd = ~{{(W2 - W - WH){1'b0}}, r_z2, {WH{1'b0}}};
    endcase
  end

  // The low pass feeds the op's subtract +1 in; the high pass chains the stored carry.
  assign w_addA   = w_isLo ? r_acc[W-1:0]  : r_acc[W2-1:W];
  assign w_addB   = w_isLo ? w_opnd[W-1:0] : w_opnd[W2-1:W];
  assign w_addCin = w_isLo ? isSubtract(r_op) : r_carry;

  LadnerFischer32 u_adder (
    .i_a    (w_addA),
    .i_b    (w_addB),
    .i_cin  (w_addCin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = ADD_LO;
      ADD_LO:  w_nextState = ADD_HI;
      ADD_HI:  w_nextState = (r_op == LAST_OP) ? DONE : ADD_LO;
      DONE:    if (bus.out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= OP_ADD_Z1;
      r_acc     <= '0;
      r_product <= '0;
      r_z0      <= '0;
      r_z1      <= '0;
      r_z2      <= '0;
      r_carry   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_z0    <= bus.z0;
            r_z1    <= bus.z1;
            r_z2    <= bus.z2;
            r_acc   <= {bus.z2, bus.z0};
            r_op    <= OP_ADD_Z1;
            r_carry <= 1'b0;
          end
        end
        ADD_LO: begin
          r_acc[W-1:0] <= w_sum;
          r_carry      <= w_cout;
        end
        ADD_HI: begin
          r_acc[W2-1:W] <= w_sum;
          r_op          <= nextOp(r_op);
          if (r_op == LAST_OP) r_product <= {w_sum, r_acc[W-1:0]};
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.product   = r_product;

endmodule
